cg_write_scheduler: RTL and testbench

- Sequences and shares the write port of a bank of enable-gated 32-bit registers between several requesters.
- Each bank register has the usual interface: data in, CLK, EN, data out; it captures data on a CLK rising edge when EN=1.
- Performs round-robin arbitration and drives a shared data bus plus one-hot per-register EN lines.
- Saves power in two ways: it suppresses EN for redundant writes (data equal to the stored value), and it flags bank idleness so the top level can gate CLK.

---
 rtl/cg_write_scheduler.sv | 120 ++++++++++++
 tb/tb_cg_write_scheduler.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/cg_write_scheduler.sv
// Round-robin write scheduler for a bank of enable-gated registers. Drops
// redundant writes using per-register shadow copies and flags bank idleness.
module cg_write_scheduler #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 2,
    parameter int IDLE_CYC = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NREQ-1:0]          REQ,
    input  logic [NREQ*ADDR_W-1:0]   REQ_ADDR,
    input  logic [NREQ*WIDTH-1:0]    REQ_DATA,
    output logic [NREQ-1:0]          GNT,
    output logic [WIDTH-1:0]         D_OUT,
    output logic [(2**ADDR_W)-1:0]   EN_OUT,
    output logic                     SLEEP,
    output logic [15:0]              SUPPRESS_CNT
);
    localparam int NREG   = 2**ADDR_W;
    localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int IDLE_W = $clog2(IDLE_CYC + 1);

    logic [NREQ-1:0]             gnt_q, gnt_d;
    logic [WIDTH-1:0]            d_out_q, d_out_d;
    logic [NREG-1:0]             en_out_q, en_out_d;
    logic [15:0]                 sup_cnt_q, sup_cnt_d;
    logic [PTR_W-1:0]            ptr_q, ptr_d;
    logic [IDLE_W-1:0]           idle_q, idle_d;
    logic [NREG-1:0][WIDTH-1:0]  shadow_q, shadow_d;
    logic [NREG-1:0]             shadow_vld_q, shadow_vld_d;

    logic [NREQ-1:0]   eligible;
    logic              found;
    logic [PTR_W-1:0]  win;
    logic [PTR_W-1:0]  cand;
    logic [ADDR_W-1:0] sel_addr;
    logic [WIDTH-1:0]  sel_data;

    // Mask the live grant so a requester still holding REQ in its grant
    // cycle is not granted the same transaction twice.
    assign eligible = REQ & ~gnt_q;

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            int tmp;
            tmp = int'(ptr_q) + k;
            if (tmp >= NREQ) tmp = tmp - NREQ;
            cand = PTR_W'(tmp);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign sel_addr = REQ_ADDR[win*ADDR_W +: ADDR_W];
    assign sel_data = REQ_DATA[win*WIDTH +: WIDTH];

    always_comb begin
        gnt_d        = '0;
        en_out_d     = '0;
        d_out_d      = d_out_q;
        sup_cnt_d    = sup_cnt_q;
        ptr_d        = ptr_q;
        shadow_d     = shadow_q;
        shadow_vld_d = shadow_vld_q;
        idle_d       = idle_q;

        if (found) begin
            gnt_d[win] = 1'b1;
            d_out_d    = sel_data;
            ptr_d      = (int'(win) == NREQ - 1) ? '0 : win + PTR_W'(1);
            if (shadow_vld_q[sel_addr] && shadow_q[sel_addr] == sel_data) begin
                if (sup_cnt_q != 16'hFFFF) sup_cnt_d = sup_cnt_q + 16'd1;
            end else begin
                en_out_d[sel_addr]     = 1'b1;
                shadow_d[sel_addr]     = sel_data;
                shadow_vld_d[sel_addr] = 1'b1;
            end
        end

        if (REQ != '0)
            idle_d = '0;
        else if (gnt_q == '0 && idle_q != IDLE_W'(IDLE_CYC))
            idle_d = idle_q + IDLE_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            gnt_q        <= '0;
            d_out_q      <= '0;
            en_out_q     <= '0;
            sup_cnt_q    <= '0;
            ptr_q        <= '0;
            idle_q       <= '0;
            shadow_q     <= '0;
            shadow_vld_q <= '0;
        end else begin
            gnt_q        <= gnt_d;
            d_out_q      <= d_out_d;
            en_out_q     <= en_out_d;
            sup_cnt_q    <= sup_cnt_d;
            ptr_q        <= ptr_d;
            idle_q       <= idle_d;
            shadow_q     <= shadow_d;
            shadow_vld_q <= shadow_vld_d;
        end
    end

    assign GNT          = gnt_q;
    assign D_OUT        = d_out_q;
    assign EN_OUT       = en_out_q;
    assign SUPPRESS_CNT = sup_cnt_q;
    assign SLEEP        = (idle_q == IDLE_W'(IDLE_CYC));

endmodule

// File: tb/tb_cg_write_scheduler.sv
// Directed bench for cg_write_scheduler: single/redundant writes, round robin,
// grant masking, sleep/wake and reset mid-operation.
module tb_cg_write_scheduler;
    localparam int NREQ = 4, WIDTH = 32, ADDR_W = 2, NREG = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*WIDTH-1:0]  req_data;
    logic [NREQ-1:0]        gnt;
    logic [WIDTH-1:0]       d_out;
    logic [NREG-1:0]        en_out;
    logic                   sleep;
    logic [15:0]            sup_cnt;

    int n_chk = 0;
    int n_err = 0;

    cg_write_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .ADDR_W(ADDR_W), .IDLE_CYC(8)) dut (
        .CLK(clk), .RST(rst), .REQ(req), .REQ_ADDR(req_addr), .REQ_DATA(req_data),
        .GNT(gnt), .D_OUT(d_out), .EN_OUT(en_out), .SLEEP(sleep), .SUPPRESS_CNT(sup_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*WIDTH +: WIDTH]   = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        step();
        rst = 1'b0;
    endtask

    logic [3:0] exp_g [5];
    logic [3:0] exp_e [5];

    initial begin
        rst = 1'b1; req = '0; req_addr = '0; req_data = '0;

        // reset then single write
        step();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_en", 32'(en_out), 0);
        chk("rst_dout", d_out, 0);
        chk("rst_sleep", 32'(sleep), 0);
        chk("rst_cnt", 32'(sup_cnt), 0);
        rst = 1'b0;
        req = 4'b0001; set_req(0, 2, 32'd1);
        step();
        chk("w1_gnt", 32'(gnt), 32'b0001);
        chk("w1_en", 32'(en_out), 32'b0100);
        chk("w1_dout", d_out, 1);
        req = '0;
        step();
        chk("w1_en_off", 32'(en_out), 0);
        chk("w1_gnt_off", 32'(gnt), 0);
        chk("w1_dout_hold", d_out, 1);

        // redundant write, then a changed value
        req = 4'b0001; set_req(0, 2, 32'd1);
        step();
        chk("red_gnt", 32'(gnt), 32'b0001);
        chk("red_en", 32'(en_out), 0);
        chk("red_cnt", 32'(sup_cnt), 1);
        set_req(0, 2, 32'd13);
        step();
        chk("red_mask_gnt", 32'(gnt), 0);
        step();
        chk("new_gnt", 32'(gnt), 32'b0001);
        chk("new_en", 32'(en_out), 32'b0100);
        chk("new_dout", d_out, 13);
        chk("new_cnt", 32'(sup_cnt), 1);
        req = '0;

        // round robin with drop-after-grant, re-raise next cycle
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, ADDR_W'(i), 32'(100 + i));
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_e = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
        req = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            step();
            chk($sformatf("rr_gnt%0d", s), 32'(gnt), 32'(exp_g[s]));
            chk($sformatf("rr_en%0d", s), 32'(en_out), 32'(exp_e[s]));
            chk($sformatf("rr_dout%0d", s), d_out, (s == 4) ? 32'd100 : 32'(100 + s));
            req = 4'b1111 & ~exp_g[s];
        end
        chk("rr_cnt", 32'(sup_cnt), 1);

        // masking: single requester held continuously
        do_reset();
        req = 4'b0010; set_req(1, 1, 32'd3);
        step();
        chk("mk_gnt0", 32'(gnt), 32'b0010);
        chk("mk_en0", 32'(en_out), 32'b0010);
        chk("mk_d0", d_out, 3);
        set_req(1, 1, 32'd254);
        step();
        chk("mk_gnt1", 32'(gnt), 0);
        step();
        chk("mk_gnt2", 32'(gnt), 32'b0010);
        chk("mk_en2", 32'(en_out), 32'b0010);
        chk("mk_d2", d_out, 254);
        step();
        chk("mk_gnt3", 32'(gnt), 0);
        step();
        chk("mk_gnt4", 32'(gnt), 32'b0010);
        chk("mk_en4", 32'(en_out), 0);
        chk("mk_cnt4", 32'(sup_cnt), 1);

        // sleep after 8 idle edges, wake with same-edge grant
        do_reset();
        for (int s = 1; s <= 7; s++) step();
        chk("sl_7", 32'(sleep), 0);
        step();
        chk("sl_8", 32'(sleep), 1);
        step();
        chk("sl_9", 32'(sleep), 1);
        req = 4'b1000; set_req(3, 0, 32'd5);
        step();
        chk("wk_sleep", 32'(sleep), 0);
        chk("wk_gnt", 32'(gnt), 32'b1000);
        chk("wk_en", 32'(en_out), 32'b0001);
        req = '0;

        // reset mid-operation invalidates shadows
        do_reset();
        req = 4'b0010; set_req(1, 3, 32'd77);
        step();
        chk("mr_gnt", 32'(gnt), 32'b0010);
        chk("mr_en", 32'(en_out), 32'b1000);
        rst = 1'b1;
        step();
        chk("mr_rst_gnt", 32'(gnt), 0);
        chk("mr_rst_en", 32'(en_out), 0);
        chk("mr_rst_dout", d_out, 0);
        rst = 1'b0;
        step();
        chk("mr_again_gnt", 32'(gnt), 32'b0010);
        chk("mr_again_en", 32'(en_out), 32'b1000);
        chk("mr_again_cnt", 32'(sup_cnt), 0);
        req = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
